// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling 8N1 UART receiver with valid/ready byte output
module uart_rx_os16 #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_enable,
   input  logic                  rx_in,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  busy
);

   localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * 16);
   localparam int TW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam int BW     = $clog2(DATA_WIDTH + 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(OS_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state;
   logic                  sync1;
   logic                  sync2;
   logic                  rx_prev;
   logic                  rx_s;
   logic                  fall;
   logic                  tick;
   logic [TW-1:0]         tick_cnt;
   logic [3:0]            samp_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;

   assign rx_s = sync2;
   assign fall = rx_prev & ~rx_s;
   assign tick = (tick_cnt == TICK_MAX);
   assign busy = (state != IDLE);

   // Two-flop synchroniser plus previous-sample flop for falling-edge detection; idle line is high
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx_in;
         sync2   <= sync1;
         rx_prev <= sync2;
      end
   end

   // Oversample tick divider; restarted on an accepted start edge so bit centres line up with the edge
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (state == IDLE && rx_enable && fall) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Receive FSM: start validation at mid-bit, centre sampling of data/stop, output handshake and error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         samp_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         // Accept clears valid; a byte loaded on the same edge below overrides this
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (!rx_enable) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (fall) begin
                     state    <= START;
                     samp_cnt <= '0;
                  end
               end
               START: begin
                  if (tick) begin
                     if (samp_cnt == 4'd7) begin
                        samp_cnt <= '0;
                        bit_cnt  <= '0;
                        // A high line at the start-bit centre was a glitch
                        state    <= rx_s ? IDLE : DATA;
                     end else begin
                        samp_cnt <= samp_cnt + 4'd1;
                     end
                  end
               end
               DATA: begin
                  if (tick) begin
                     if (samp_cnt == 4'd15) begin
                        samp_cnt <= '0;
                        shreg    <= {rx_s, shreg[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                           state <= STOP;
                        end else begin
                           bit_cnt <= bit_cnt + 1'b1;
                        end
                     end else begin
                        samp_cnt <= samp_cnt + 4'd1;
                     end
                  end
               end
               STOP: begin
                  if (tick) begin
                     if (samp_cnt == 4'd15) begin
                        samp_cnt <= '0;
                        state    <= IDLE;
                        if (rx_s) begin
                           if (!rx_valid || rx_ready) begin
                              rx_data  <= shreg;
                              rx_valid <= 1'b1;
                           end else begin
                              overrun <= 1'b1;
                           end
                        end else begin
                           frame_err <= 1'b1;
                        end
                     end else begin
                        samp_cnt <= samp_cnt + 4'd1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - scoreboard bench for uart_rx_os16 at 160 clk per bit
module tb_uart_rx_os16;

   localparam int BIT = 160;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_enable = 1'b0;
   logic       rx_in = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   int         fe_cycles = 0;
   int         ov_cycles = 0;
   logic [7:0] exp_q[$];

   uart_rx_os16 #(
      .CLK_FREQ  (1_536_000),
      .BAUD_RATE (9600),
      .DATA_WIDTH(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_enable(rx_enable),
      .rx_in    (rx_in),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      rx_in = 1'b0;
      cyc(BIT);
      for (int i = 0; i < 8; i++) begin
         rx_in = d[i];
         cyc(BIT);
      end
      rx_in = stop_bit;
      cyc(BIT);
      rx_in = 1'b1;
   endtask

   task automatic wait_valid(input int budget, output int lat);
      lat = 0;
      while (!rx_valid && lat < budget) begin
         cyc(1);
         lat++;
      end
      chk("valid_seen", rx_valid, 1);
   endtask

   // Scoreboard: every accepted byte must match the oldest expected byte; count error-flag high cycles
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", rx_data, 32'hFFFF_FFFF);
            end else begin
               chk("rx_data", rx_data, exp_q.pop_front());
            end
         end
         if (frame_err) fe_cycles++;
         if (overrun) ov_cycles++;
      end
   end

   initial begin
      int  lat;
      logic saw_busy;

      cyc(5);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      rst = 1'b0;
      rx_enable = 1'b1;
      cyc(20);

      // 1: single frame, consumer not ready
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1);
         wait_valid(2000, lat);
      join
      chk("t1_latency", (lat >= 1515 && lat <= 1530), 1);
      cyc(500);
      chk("t1_hold_valid", rx_valid, 1);
      chk("t1_hold_data", rx_data, 8'hA5);
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
      chk("t1_valid_fall", rx_valid, 0);
      cyc(100);

      // 2: start glitch
      saw_busy = 1'b0;
      rx_in = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         saw_busy |= busy;
      end
      rx_in = 1'b1;
      for (int i = 0; i < 200; i++) begin
         cyc(1);
         saw_busy |= busy;
      end
      chk("t2_busy_seen", saw_busy, 1);
      chk("t2_idle", busy, 0);
      chk("t2_no_valid", rx_valid, 0);
      chk("t2_no_ferr", fe_cycles, 0);

      // 3: framing error
      send_frame(8'h3C, 1'b0);
      cyc(200);
      chk("t3_ferr_once", fe_cycles, 1);
      chk("t3_no_valid", rx_valid, 0);
      chk("t3_data_kept", rx_data, 8'hA5);

      // 4: overrun
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      cyc(200);
      chk("t4_ovr_once", ov_cycles, 1);
      chk("t4_valid_held", rx_valid, 1);
      chk("t4_data_old", rx_data, 8'h11);
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
      chk("t4_valid_fall", rx_valid, 0);
      cyc(100);

      // 5: back-to-back frames, always ready
      rx_ready = 1'b1;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      cyc(200);
      chk("t5_q_empty", exp_q.size(), 0);
      chk("t5_no_ovr", ov_cycles, 1);
      chk("t5_no_ferr", fe_cycles, 1);

      // rx_enable dropped mid-frame
      fork
         send_frame(8'h77, 1'b1);
         begin
            cyc(500);
            rx_enable = 1'b0;
            cyc(1);
            chk("en_abort_idle", busy, 0);
         end
      join
      cyc(50);
      rx_enable = 1'b1;
      cyc(50);
      chk("en_no_valid", rx_valid, 0);
      chk("en_no_flags", fe_cycles + ov_cycles, 2);

      // 6: reset during data bit 3 of 0x96, then a clean frame
      rx_in = 1'b0;
      cyc(BIT);
      for (int i = 0; i < 3; i++) begin
         rx_in = 8'h96 >> i;
         cyc(BIT);
      end
      rx_in = 1'b0;
      cyc(80);
      chk("t6_busy_mid", busy, 1);
      rst = 1'b1;
      cyc(1);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_valid", rx_valid, 0);
      chk("t6_rst_data", rx_data, 0);
      rst = 1'b0;
      rx_in = 1'b1;
      cyc(320);
      exp_q.push_back(8'h5A);
      fork
         send_frame(8'h5A, 1'b1);
         wait_valid(2000, lat);
      join
      cyc(50);
      chk("t6_data", rx_data, 8'h5A);

      chk("end_q_empty", exp_q.size(), 0);
      chk("end_ferr_total", fe_cycles, 1);
      chk("end_ovr_total", ov_cycles, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
